// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC into a combinational instruction memory, buffers fetched
// words in a small FIFO for the issue stage, and handles branch redirects and halt draining.
module fetch_sequencer #(
  parameter int unsigned       QDEPTH   = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [ADDR_W-1:0]         mem_pc,
  input  logic [31:0]               mem_instr,
  input  logic                      mem_isdone,
  output logic                      issue_valid,
  output logic [31:0]               issue_instr,
  output logic [ADDR_W-1:0]         issue_pc,
  input  logic                      issue_ready,
  input  logic                      redirect_valid,
  input  logic [ADDR_W-1:0]         redirect_pc,
  output logic                      halted,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int unsigned PtrW = $clog2(QDEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Full = CntW'(QDEPTH);

  typedef enum logic [1:0] {StFetch, StDrain, StHalted} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;

  logic [31:0]       instr_q [QDEPTH];
  logic [ADDR_W-1:0] ipc_q   [QDEPTH];

  logic deq, enq_ok, push, flush;

  assign deq    = issue_valid & issue_ready;
  // A full queue can still take a word when the head leaves in the same cycle.
  assign enq_ok = (count_q < Full) | deq;
  assign flush  = redirect_valid & (state_q != StHalted);
  assign push   = (state_q == StFetch) & ~redirect_valid & enq_ok & ~mem_isdone;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch: begin
        if (flush) begin
          state_d = StFetch;
        end else if (enq_ok && mem_isdone) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (flush) begin
          state_d = StFetch;
        end else if (count_q == '0) begin
          state_d = StHalted;
        end
      end
      StHalted: state_d = StHalted;
      default:  state_d = StFetch;
    endcase
  end

  // Output logic
  always_comb begin
    issue_valid = (count_q != '0) && (state_q != StHalted);
    halted      = (state_q == StHalted);
    issue_instr = instr_q[rd_ptr_q];
    issue_pc    = ipc_q[rd_ptr_q];
    mem_pc      = pc_q;
    q_count     = count_q;
  end

  // Datapath next state; a redirect discards everything, including a same-cycle fetch.
  always_comb begin
    pc_d     = pc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      pc_d     = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + ADDR_W'(1);
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({push, deq})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_q[wr_ptr_q] <= mem_instr;
      ipc_q[wr_ptr_q]   <= pc_q;
    end
  end

endmodule
